// File: rtl/simon_pkg.sv
// Shared Simon128/128 definitions: block/word types, round function f and the
// decryption FSM state encoding. Used by both the encryption and decryption rounds.
package simon_pkg;

  localparam int ROUNDS_128_128 = 68;

  typedef logic [63:0]  word_t;
  typedef logic [127:0] bloco_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } estado_t;

  // f(v) = (rotl1(v) & rotl8(v)) ^ rotl2(v) on 64-bit words
  function automatic word_t f(input word_t v);
    return ({v[62:0], v[63]} & {v[55:0], v[63:56]}) ^ {v[61:0], v[63:62]};
  endfunction

endpackage

// File: rtl/rodada_inv_simon.sv
// Combinational inverse Simon round: (x,y) -> (y, x ^ f(y) ^ k).
module rodada_inv_simon
  import simon_pkg::*;
(
  input  bloco_t blk_i,
  input  word_t  key_i,
  output bloco_t blk_o
);

  word_t x;
  word_t y;

  assign x     = blk_i[127:64];
  assign y     = blk_i[63:0];
  assign blk_o = {y, x ^ f(y) ^ key_i};

endmodule

// File: rtl/decifra_simon.sv
// Iterative Simon128/128 decryption: one inverse round per clock, round keys
// requested from ROUNDS-1 down to 0. Define DECIFRA_SIMON_CLEAR_EN to zero the
// state register on the output handshake.
module decifra_simon
  import simon_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_128_128,
  parameter int KIW    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ct_valid_i,
  output logic           ct_ready_o,
  input  logic [127:0]   ct_i,
  output logic [KIW-1:0] rk_idx_o,
  input  logic [63:0]    rk_i,
  output logic           pt_valid_o,
  input  logic           pt_ready_i,
  output logic [127:0]   pt_o,
  output logic           busy_o
);

  localparam logic [KIW-1:0] CNT_INI = KIW'(ROUNDS - 1);

  estado_t        state_q, state_d;
  logic [KIW-1:0] cnt_q, cnt_d;
  bloco_t         blk_q, blk_d;
  bloco_t         blk_nxt;

  rodada_inv_simon u_rodada (
    .blk_i (blk_q),
    .key_i (rk_i),
    .blk_o (blk_nxt)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    unique case (state_q)
      IDLE: begin
        if (ct_valid_i) begin
          blk_d   = ct_i;
          cnt_d   = CNT_INI;
          state_d = RUN;
        end
      end
      RUN: begin
        blk_d = blk_nxt;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - KIW'(1);
      end
      DONE: begin
        if (pt_ready_i) begin
          state_d = IDLE;
          cnt_d   = CNT_INI;
`ifdef DECIFRA_SIMON_CLEAR_EN
          blk_d   = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the datapath register is reset too, so pt_o reads 0 after reset and
    // an aborted block leaves nothing behind.
    if (rst) begin
      // NOTE: non-blocking assignments keep all flops updating from the same
      // pre-edge values regardless of statement order.
      state_q <= IDLE;
      cnt_q   <= CNT_INI;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
    end
  end

  assign ct_ready_o = (state_q == IDLE);
  assign pt_valid_o = (state_q == DONE);
  assign busy_o     = (state_q == RUN);
  assign pt_o       = blk_q;
  assign rk_idx_o   = cnt_q;

endmodule

// File: tb/tb_decifra_simon.sv
// Self-checking bench for decifra_simon: KAT, key order, backpressure, mid-run
// reset and random round trips against a behavioural Simon128/128 model.
`timescale 1ns/1ps
module tb_decifra_simon;

  localparam int ROUNDS = 68;
  localparam int KIW    = $clog2(ROUNDS);

  localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] KAT_PT  = 128'h63736564207372656c6c657661727420;
  localparam logic [127:0] KAT_CT  = 128'h49681b1e1e54fe3f65aa832af84e0bbc;

  logic           clk = 1'b0;
  logic           rst;
  logic           ct_valid_i;
  logic           ct_ready_o;
  logic [127:0]   ct_i;
  logic [KIW-1:0] rk_idx_o;
  logic [63:0]    rk_i;
  logic           pt_valid_o;
  logic           pt_ready_i;
  logic [127:0]   pt_o;
  logic           busy_o;

  logic [63:0] rk_tab [ROUNDS];
  int n_checks = 0;
  int n_errors = 0;

  decifra_simon #(.ROUNDS(ROUNDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .ct_valid_i (ct_valid_i),
    .ct_ready_o (ct_ready_o),
    .ct_i       (ct_i),
    .rk_idx_o   (rk_idx_o),
    .rk_i       (rk_i),
    .pt_valid_o (pt_valid_o),
    .pt_ready_i (pt_ready_i),
    .pt_o       (pt_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  assign rk_i = rk_tab[rk_idx_o];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [63:0] fm(input logic [63:0] v);
    return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
  endfunction

  // Simon128/128 key schedule (m=2, constant sequence z2, LSB first)
  task automatic expand_key(input logic [127:0] key);
    logic [63:0] z;
    logic [63:0] t;
    z = 64'h7369f885192c0ef5;
    rk_tab[0] = key[63:0];
    rk_tab[1] = key[127:64];
    for (int i = 0; i < ROUNDS - 2; i++) begin
      t = rotl(rk_tab[i+1], 61) ^ rotl(rk_tab[i+1], 60);
      rk_tab[i+2] = ~rk_tab[i] ^ 64'd3 ^ {63'd0, z[i % 62]} ^ t;
    end
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] p);
    logic [63:0] x, y, t;
    x = p[127:64];
    y = p[63:0];
    for (int r = 0; r < ROUNDS; r++) begin
      t = x;
      x = y ^ fm(x) ^ rk_tab[r];
      y = t;
    end
    return {x, y};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ct_ready"}, ct_ready_o, 1);
    check({tag, "_pt_valid"}, pt_valid_o, 0);
    check({tag, "_pt_o"},     pt_o, 0);
    check({tag, "_busy"},     busy_o, 0);
    check({tag, "_rk_idx"},   rk_idx_o, ROUNDS - 1);
  endtask

  // Runs one block from the current negedge; abort_at >= 0 resets after that many rounds.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] exp,
                           input int hold, input bit toggle, input int abort_at);
    int lat;
    int nk;
    int w;
    int pulses;
    bit order_ok;
    bit stall_ok;
    logic [127:0] held;
    w = 0;
    while (!ct_ready_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_load", ct_ready_o, 1);
    ct_i       = ct;
    ct_valid_i = 1'b1;
    pt_ready_i = (hold == 0);
    @(negedge clk);
    ct_valid_i = 1'b0;
    ct_i       = rand128();
    lat      = 0;
    nk       = 0;
    order_ok = 1'b1;
    while (!pt_valid_o && lat < 4 * ROUNDS) begin
      if (busy_o) begin
        if (rk_idx_o != KIW'(ROUNDS - 1 - nk) || ct_ready_o) order_ok = 1'b0;
        nk++;
      end
      if (lat == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("mid_reset");
        pulses = 0;
        for (int i = 0; i < ROUNDS + 5; i++) begin
          @(negedge clk);
          if (pt_valid_o || busy_o) pulses++;
        end
        check("mid_reset_no_output", pulses, 0);
        return;
      end
      if (toggle) begin
        ct_valid_i = 1'($urandom_range(0, 1));
        ct_i       = rand128();
      end
      @(negedge clk);
      lat++;
    end
    ct_valid_i = 1'b0;
    check("latency",    lat, ROUNDS);
    check("key_count",  nk, ROUNDS);
    check("key_order",  order_ok, 1);
    check("plaintext",  pt_o, exp);
    if (hold > 0) begin
      held     = pt_o;
      stall_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        if (!pt_valid_o || pt_o !== held || ct_ready_o) stall_ok = 1'b0;
        if (i < hold - 1) @(negedge clk);
      end
      check("backpressure_stable", stall_ok, 1);
      pt_ready_i = 1'b1;
    end
    @(negedge clk);
    check("handshake_done", pt_valid_o, 0);
    check("idle_ready",     ct_ready_o, 1);
    check("idle_busy",      busy_o, 0);
`ifdef DECIFRA_SIMON_CLEAR_EN
    check("pt_after_hs", pt_o, 0);
`else
    check("pt_after_hs", pt_o, exp);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] key, pt, ct;
    rst        = 1'b1;
    ct_valid_i = 1'b0;
    pt_ready_i = 1'b0;
    ct_i       = '0;
    expand_key(KAT_KEY);
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("model_kat", encrypt(KAT_PT), KAT_CT);

    run_block(KAT_CT, KAT_PT, 0, 1'b0, -1);
    run_block(KAT_CT, KAT_PT, 10, 1'b0, -1);
    run_block(KAT_CT, KAT_PT, 0, 1'b0, 30);
    run_block(KAT_CT, KAT_PT, 0, 1'b0, -1);

    for (int n = 0; n < 200; n++) begin
      key = rand128();
      pt  = rand128();
      expand_key(key);
      ct  = encrypt(pt);
      run_block(ct, pt, $urandom_range(0, 3), 1'b1, -1);
    end

    expand_key(KAT_KEY);
    run_block(KAT_CT, KAT_PT, 2, 1'b0, -1);
    for (int i = 0; i < 3; i++) @(negedge clk);
`ifdef DECIFRA_SIMON_CLEAR_EN
    check("pt_idle_hold", pt_o, 0);
`else
    check("pt_idle_hold", pt_o, KAT_PT);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
